ifft_frame_ctrl: RTL
====================

// Module: ifft_frame_ctrl
// PURPOSE
//   Return path of the spectral processing chain: collects one frame of complex products (FFT bin x stored
//   coefficient) from the complex multiplier, quantises them to 16-bit, and streams the frame into the
//   xfft core configured as IFFT over AXI-Stream. Receives the time-domain output and converts the real
//   part to offset-binary samples for the 10-bit DAC (da_data). Owns the IFFT config handshake and framing.
// PARAMETERS
//   FFT_LEN   1024  samples per frame (power of 2)
//   LOG2_LEN  10    log2(FFT_LEN)
//   IN_W      33    signed width of prod_real/prod_imag
//   SHIFT     12    arithmetic right shift applied to products before 16-bit saturation
// PORTS
//   sys_clk      in   1      single clock for all logic
//   sys_rst      in   1      reset, synchronous, active-high
//   run          in   1      level: 1 = process frames continuously; 0 = stop after current frame
//   prod_valid   in   1      product sample valid (no backpressure upstream)
//   prod_real    in   IN_W   signed real part of product
//   prod_imag    in   IN_W   signed imag part of product
//   cfg_tdata    out  8      IFFT config word, constant 8'h00 (bit0=0 selects inverse)
//   cfg_tvalid   out  1      config valid
//   cfg_tready   in   1      config ready from xfft
//   s_tdata      out  32     {imag16, real16} to xfft, real in [15:0]
//   s_tvalid     out  1      data valid to xfft
//   s_tready     in   1      xfft ready
//   s_tlast      out  1      high on sample FFT_LEN-1 of each frame
//   m_tdata      in   32     xfft output {imag16, real16}
//   m_tvalid     in   1      xfft output valid
//   m_tlast      in   1      xfft output last
//   m_tready     out  1      accept xfft output
//   da_data      out  10     DAC sample, offset binary
//   da_valid     out  1      1-cycle strobe per new da_data
//   frame_done   out  1      1-cycle pulse after last output sample of a frame
//   err_tlast    out  1      sticky: m_tlast position mismatch; cleared only by sys_rst
// BEHAVIOUR
//   Reset (sys_rst=1 at edge): state=IDLE, all counters 0; cfg_tvalid, s_tvalid, s_tlast, m_tready,
//     da_valid, frame_done, err_tlast = 0; s_tdata = 0; da_data = 10'h200 (mid-scale). Mid-frame reset
//     aborts all activity immediately; partial frame discarded.
//   FSM: IDLE -> CONFIG when run=1.
//     CONFIG: cfg_tvalid=1; on cfg_tvalid&cfg_tready -> LOAD next cycle. Config sent once per run-start.
//     LOAD: each prod_valid writes quantised sample to frame RAM at wr_idx, wr_idx++; on write of
//       index FFT_LEN-1 -> STREAM. prod_valid outside LOAD is ignored (dropped).
//     STREAM: RAM read latency 1; s_tdata/s_tvalid come from an output register prefetched so s_tvalid
//       is contiguous while s_tready=1. Index advances only on s_tvalid&s_tready; s_tdata, s_tvalid,
//       s_tlast held stable while s_tready=0. s_tlast=1 exactly with index FFT_LEN-1. After that beat -> DRAIN.
//     DRAIN: m_tready=1. Each m_tvalid beat: rd_cnt++, da_data/da_valid updated next cycle.
//       On m_tlast beat: err_tlast set if rd_cnt != FFT_LEN-1; frame_done pulses next cycle;
//       state -> LOAD if run=1, else IDLE (rd_cnt cleared). m_tready=0 outside DRAIN.
//   Quantisation (LOAD): q = x >>> SHIFT (arithmetic); clamp to [-32768, 32767]; real and imag independently.
//   DAC conversion: r = m_tdata[15:0] signed; da_data = {~r[15], r[14:6]} (top 10 bits, offset binary).
//   Latency: m_tvalid beat at cycle t -> da_data/da_valid at t+1. da_data holds last value between strobes.
//   run deasserted in CONFIG/LOAD/STREAM: current frame completes, then IDLE.
// TESTING
//   T1 reset: hold sys_rst 2 cycles mid-STREAM -> all strobes 0, da_data=10'h200, s_tvalid=0 next cycle.
//   T2 config: run=1, cfg_tready low 5 cycles -> cfg_tvalid stays 1 with cfg_tdata=8'h00; no LOAD writes counted.
//   T3 quantise: prod_real=33'sd4096 -> real16=1; prod_real=-(2**31) -> real16=-32768 (sat); 2**30 -> 32767.
//   T4 backpressure: random s_tready 50% -> exactly FFT_LEN beats, data in write order, s_tlast only on beat 1023.
//   T5 DAC: m_tdata real=16'h7FFF -> da_data=10'h3FF; 16'h8000 -> 10'h000; 16'h0000 -> 10'h200; da_valid 1 cycle.
//   T6 framing: m_tlast early at beat 500 -> err_tlast=1 sticky, frame_done pulse, next frame runs if run=1.

Source files
------------

// File: rtl/ifft_frame_ctrl_if.sv
// AXI-Stream bundle between the frame controller and the xfft core:
// config channel (cfg_*), frame input (s_*), time-domain output (m_*).
interface ifft_frame_ctrl_if;
    logic [7:0]  cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;

    // Controller side
    modport master (
        output cfg_tdata, cfg_tvalid,
        input  cfg_tready,
        output s_tdata, s_tvalid, s_tlast,
        input  s_tready,
        input  m_tdata, m_tvalid, m_tlast,
        output m_tready
    );

    // xfft side
    modport slave (
        input  cfg_tdata, cfg_tvalid,
        output cfg_tready,
        input  s_tdata, s_tvalid, s_tlast,
        output s_tready,
        output m_tdata, m_tvalid, m_tlast,
        input  m_tready
    );
endinterface

// File: rtl/ifft_frame_ctrl.sv
// IFFT return path: buffers one frame of quantised complex products,
// streams it to the xfft core and converts its real output for the DAC.
// Ports: sys_clk/sys_rst (sync, active-high); run level; prod_* input
// samples; axis (master) carries cfg/s/m AXI-Stream channels;
// da_data/da_valid DAC output; frame_done pulse; err_tlast sticky flag.
module ifft_frame_ctrl #(
    parameter int FFT_LEN  = 1024,
    parameter int LOG2_LEN = 10,
    parameter int IN_W     = 33,
    parameter int SHIFT    = 12
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   run,
    input  logic                   prod_valid,
    input  logic signed [IN_W-1:0] prod_real,
    input  logic signed [IN_W-1:0] prod_imag,
    ifft_frame_ctrl_if.master      axis,
    output logic [9:0]             da_data,
    output logic                   da_valid,
    output logic                   frame_done,
    output logic                   err_tlast
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_LOAD,
        S_STREAM,
        S_DRAIN
    } state_t;

    localparam logic [LOG2_LEN-1:0] LAST = LOG2_LEN'(FFT_LEN - 1);
    localparam logic signed [IN_W-1:0] QMAX = $signed(IN_W'(32767));
    localparam logic signed [IN_W-1:0] QMIN = -$signed(IN_W'(32768));

    state_t              state_q, state_d;
    logic [LOG2_LEN-1:0] idx_q, idx_d;
    logic [LOG2_LEN-1:0] rd_cnt_q, rd_cnt_d;
    logic                s_tvalid_q, s_tvalid_d;
    logic [9:0]          da_data_q, da_data_d;
    logic                da_valid_q, da_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                err_q, err_d;

    logic                wr_en;
    logic [LOG2_LEN-1:0] rd_addr;
    logic [31:0]         wdata;
    logic [31:0]         ram_q;
    logic [31:0]         mem [FFT_LEN];
    logic                cfg_tvalid_c;
    logic                m_tready_c;
    logic                unused_bits;

    function automatic logic [15:0] quant(input logic signed [IN_W-1:0] x);
        logic signed [IN_W-1:0] s;
        s = x >>> SHIFT;
        if (s > QMAX) begin
            return 16'h7FFF;
        end else if (s < QMIN) begin
            return 16'h8000;
        end
        return s[15:0];
    endfunction

    assign wdata = {quant(prod_imag), quant(prod_real)};

    // Frame buffer; the read address follows the handshake combinationally
    // so ram_q always holds the word at the current stream index.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[idx_q] <= wdata;
        end
        ram_q <= mem[rd_addr];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            rd_cnt_q     <= '0;
            s_tvalid_q   <= 1'b0;
            da_data_q    <= 10'h200;
            da_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rd_cnt_q     <= rd_cnt_d;
            s_tvalid_q   <= s_tvalid_d;
            da_data_q    <= da_data_d;
            da_valid_q   <= da_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rd_cnt_d     = rd_cnt_q;
        s_tvalid_d   = 1'b0;
        da_data_d    = da_data_q;
        da_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        wr_en        = 1'b0;
        rd_addr      = idx_q;
        cfg_tvalid_c = 1'b0;
        m_tready_c   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_CONFIG;
                end
            end
            S_CONFIG: begin
                cfg_tvalid_c = 1'b1;
                if (axis.cfg_tready) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (prod_valid) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                // Valid rises one cycle after entry, once ram_q is primed.
                s_tvalid_d = 1'b1;
                if (s_tvalid_q && axis.s_tready) begin
                    idx_d   = idx_q + 1'b1;
                    rd_addr = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        s_tvalid_d = 1'b0;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                m_tready_c = 1'b1;
                if (axis.m_tvalid) begin
                    rd_cnt_d   = rd_cnt_q + 1'b1;
                    da_valid_d = 1'b1;
                    da_data_d  = {~axis.m_tdata[15], axis.m_tdata[14:6]};
                    if (axis.m_tlast) begin
                        frame_done_d = 1'b1;
                        rd_cnt_d     = '0;
                        if (rd_cnt_q != LAST) begin
                            err_d = 1'b1;
                        end
                        state_d = run ? S_LOAD : S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign unused_bits = ^{axis.m_tdata[31:16], axis.m_tdata[5:0]};

    assign axis.cfg_tdata  = 8'h00;
    assign axis.cfg_tvalid = cfg_tvalid_c;
    assign axis.s_tvalid   = s_tvalid_q;
    assign axis.s_tdata    = s_tvalid_q ? ram_q : 32'h0;
    assign axis.s_tlast    = s_tvalid_q && (idx_q == LAST);
    assign axis.m_tready   = m_tready_c;

    assign da_data    = da_data_q;
    assign da_valid   = da_valid_q;
    assign frame_done = frame_done_q;
    assign err_tlast  = err_q;

endmodule
